// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with valid/ready handshakes on both sides.
// Optional SERIAL_ADDER_OVF_EN adds a signed-overflow flag output (ovf).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_s;
    logic bit_c;

    // Single full-adder stage operating on the current LSBs and registered carry.
    always_comb begin
        bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        bit_c = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    end

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                // New bit enters at the MSB so the result ends LSB-aligned after WIDTH steps.
                sum_sr_d = (sum_sr_q >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
                carry_d  = bit_c;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                    sum_d   = sum_sr_d;
                    cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final step.
                    ovf_d   = carry_q ^ bit_c;
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // WIDTH=8 instance
    logic       iv8, ir8, ci8, ov8, or8, co8, bz8;
    logic [7:0] a8, b8, s8;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
`endif

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    // WIDTH=4 instance
    logic       iv4, ir4, ci4, ov4, or4, co4, bz4, en4;
    logic [3:0] a4, b4, s4;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf4;
`endif

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(ci4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(bz4)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf4)
`endif
    );

    logic [9:0] exp8_q[$];
    int         acc8_q[$];
    logic [5:0] exp4_q[$];
    int         acc4_q[$];

    // {ovf, cout, sum}; ovf is signed overflow: equal operand signs, different result sign
    function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {8'd0, c};
        v = (a[7] == b[7]) && (t[7] != a[7]);
        return {v, t};
    endfunction

    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] t;
        logic       v;
        t = {1'b0, a} + {1'b0, b} + {4'd0, c};
        v = (a[3] == b[3]) && (t[3] != a[3]);
        return {v, t};
    endfunction

    logic       prev8, prev4;
    logic [9:0] e8;
    logic [5:0] e4;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev8 = 1'b0;
        end else begin
            if (ov8 && !prev8) begin
                if (acc8_q.size() == 0) check("out8_unexpected", 64'd1, 64'd0);
                else check("lat8", 64'(cyc - acc8_q.pop_front()), 64'd8);
            end
            if (ov8 && or8 && exp8_q.size() != 0) begin
                e8 = exp8_q.pop_front();
                check("sum8", 64'(s8), 64'(e8[7:0]));
                check("cout8", 64'(co8), 64'(e8[8]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf8", 64'(ovf8), 64'(e8[9]));
`endif
            end
            prev8 = ov8;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev4 = 1'b0;
        end else begin
            if (ov4 && !prev4) begin
                if (acc4_q.size() == 0) check("out4_unexpected", 64'd1, 64'd0);
                else check("lat4", 64'(cyc - acc4_q.pop_front()), 64'd4);
            end
            if (ov4 && or4 && exp4_q.size() != 0) begin
                e4 = exp4_q.pop_front();
                check("sum4", 64'(s4), 64'(e4[3:0]));
                check("cout4", 64'(co4), 64'(e4[4]));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf4", 64'(ovf4), 64'(e4[5]));
`endif
            end
            prev4 = ov4;
        end
    end

    always @(posedge clk) begin
        #1;
        or4 = en4 ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
        iv8 = 1'b1; a8 = a; b8 = b; ci8 = c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ir8) begin
                exp8_q.push_back(model8(a, b, c));
                acc8_q.push_back(cyc + 1);
                break;
            end
            if (i == 199) check("accept8_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c);
        iv4 = 1'b1; a4 = a; b4 = b; ci4 = c;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ir4) begin
                exp4_q.push_back(model4(a, b, c));
                acc4_q.push_back(cyc + 1);
                break;
            end
            if (i == 199) check("accept4_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        iv4 = 1'b0;
    endtask

    task automatic drain8();
        for (int i = 0; i < 500 && exp8_q.size() != 0; i++) @(negedge clk);
        check("drain8_left", 64'(exp8_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic drain4();
        for (int i = 0; i < 500 && exp4_q.size() != 0; i++) @(negedge clk);
        check("drain4_left", 64'(exp4_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    logic [7:0] hold_s;
    logic       hold_c;
    logic       seen;

    initial begin
        rst_n = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; or8 = 1'b1;
        iv4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0; en4 = 1'b0;

        // Reset values before any clock edge
        #2;
        check("rst_in_ready", 64'(ir8), 64'd1);
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_busy", 64'(bz8), 64'd0);
        check("rst_sum", 64'(s8), 64'd0);
        check("rst_cout", 64'(co8), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic op and in_ready return after handshake
        send8(8'h5A, 8'h3C, 1'b0);
        check("busy_run", 64'(bz8), 64'd1);
        check("in_ready_run", 64'(ir8), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ov8;
        end
        check("t2_out_valid_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("t2_in_ready_back", 64'(ir8), 64'd1);
        check("t2_out_valid_low", 64'(ov8), 64'd0);
        @(posedge clk); #1;

        // Carry / overflow corners
        send8(8'hFF, 8'h01, 1'b0);
        send8(8'h7F, 8'h01, 1'b0);
        send8(8'hFF, 8'hFF, 1'b1);
        send8(8'h00, 8'h00, 1'b0);
        send8(8'h80, 8'h80, 1'b0);
        for (int i = 0; i < 16; i++) send8(8'($urandom), 8'($urandom), 1'($urandom));
        drain8();

        // Backpressure with a competing input request
        or8 = 1'b0;
        send8(8'h81, 8'h81, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = ov8;
        end
        check("t4_out_valid_seen", 64'(seen), 64'd1);
        hold_s = s8;
        hold_c = co8;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'b1;
            @(negedge clk);
            check("t4_out_valid_hold", 64'(ov8), 64'd1);
            check("t4_in_ready_low", 64'(ir8), 64'd0);
            check("t4_sum_hold", 64'(s8), 64'(hold_s));
            check("t4_cout_hold", 64'(co8), 64'(hold_c));
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        drain8();
        repeat (10) @(negedge clk);
        check("t4_idle_busy", 64'(bz8), 64'd0);
        check("t4_idle_ready", 64'(ir8), 64'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid-operation
        send8(8'h12, 8'h34, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", 64'(ir8), 64'd1);
        check("t5_rst_busy", 64'(bz8), 64'd0);
        check("t5_rst_out_valid", 64'(ov8), 64'd0);
        check("t5_rst_sum", 64'(s8), 64'd0);
        check("t5_rst_cout", 64'(co8), 64'd0);
        exp8_q.delete();
        acc8_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | ov8;
        end
        check("t5_no_out_valid", 64'(seen), 64'd0);
        check("t5_idle", 64'(ir8), 64'd1);
        @(posedge clk); #1;
        send8(8'h01, 8'h02, 1'b1);
        drain8();

        // WIDTH=4 exhaustive with random consumer stalls
        en4 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            send4(v[3:0], v[7:4], v[8]);
        end
        drain4();
        en4 = 1'b0;

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
